// File: rtl/mux_pkg.sv
// Shared select encodings and widths for the three-input datapath selector.
package mux_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_A    = 2'b00;
  localparam sel_t SEL_B    = 2'b01;
  localparam sel_t SEL_C    = 2'b10;
  localparam sel_t SEL_RSVD = 2'b11;

  // True for the reserved code; used by both the selector and any checker.
  function automatic logic sel_is_rsvd(input sel_t s);
    return (s == SEL_RSVD);
  endfunction

endpackage

// File: rtl/mux3_core.sv
// Combinational three-way word selector; the reserved select code yields zero.
module mux3_core
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] Q,
  output logic             is_rsvd
);

  // The default arm covers the reserved code and any unknown select, so no latch.
  always_comb begin
    Q = '0;
    unique case (sel)
      SEL_A:   Q = A;
      SEL_B:   Q = B;
      SEL_C:   Q = C;
      default: Q = '0;
    endcase
  end

  assign is_rsvd = sel_is_rsvd(sel_t'(sel));

endmodule

// File: rtl/mux3_select_reg.sv
// Three-input selector with a registered copy of the selection and select-error flags.
module mux3_select_reg
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_r,
  output logic             sel_err,
  output logic             sel_err_sticky
);

  logic is_rsvd;

  mux3_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A       (A),
    .B       (B),
    .C       (C),
    .sel     (sel),
    .Q       (Q),
    .is_rsvd (is_rsvd)
  );

  // Capture registers; reset has priority over the enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Q_r            <= '0;
      sel_err        <= 1'b0;
      sel_err_sticky <= 1'b0;
    end else if (en) begin
      Q_r            <= Q;
      sel_err        <= is_rsvd;
      sel_err_sticky <= sel_err_sticky | is_rsvd;
    end
  end

endmodule

// File: tb/tb_mux3_select_reg.sv
// Directed plus randomized checks of mux3_select_reg against a table-driven reference.
module tb_mux3_select_reg;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] c_in;
  logic [1:0]   sel;
  logic [W-1:0] q;
  logic [W-1:0] q_r;
  logic         sel_err;
  logic         sel_err_sticky;

  int n_checks;
  int n_fail;

  // Reference state: what the registered outputs should hold.
  logic [W-1:0] exp_qr;
  logic         exp_err;
  logic         exp_sticky;

  mux3_select_reg #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .A              (a_in),
    .B              (b_in),
    .C              (c_in),
    .sel            (sel),
    .Q              (q),
    .Q_r            (q_r),
    .sel_err        (sel_err),
    .sel_err_sticky (sel_err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Source table lookup; index 3 is the reserved code and reads as zero.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [1:0] s);
    logic [W-1:0] srcs [4];
    srcs[0] = a;
    srcs[1] = b;
    srcs[2] = c;
    srcs[3] = '0;
    return srcs[int'(s)];
  endfunction

  // Drive one cycle of inputs, check Q, then check registered outputs after the edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [1:0] s, input logic e, input logic r);
    logic [W-1:0] nq;
    logic         nerr;
    logic         nsticky;
    a_in  = a;
    b_in  = b;
    c_in  = c;
    sel   = s;
    en    = e;
    rst_n = r;
    #1;
    check("q", 32'(q), 32'(ref_q(a, b, c, s)));
    nq = exp_qr; nerr = exp_err; nsticky = exp_sticky;
    if (!r) begin
      nq = '0; nerr = 1'b0; nsticky = 1'b0;
    end else if (e) begin
      nq      = ref_q(a, b, c, s);
      nerr    = (s == 2'd3);
      nsticky = exp_sticky || (s == 2'd3);
    end
    @(posedge clk);
    #1;
    exp_qr = nq; exp_err = nerr; exp_sticky = nsticky;
    check("q_r", 32'(q_r), 32'(exp_qr));
    check("sel_err", 32'(sel_err), 32'(exp_err));
    check("sticky", 32'(sel_err_sticky), 32'(exp_sticky));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_qr = '0; exp_err = 1'b0; exp_sticky = 1'b0;

    // Reset for two edges with enable high.
    step(16'h1234, 16'h0, 16'h0, 2'b00, 1'b1, 1'b0);
    step(16'h1234, 16'h0, 16'h0, 2'b00, 1'b1, 1'b0);
    check("rst_q", 32'(q), 32'h1234);

    // Select A, B, C.
    step(16'h0000, 16'h0000, 16'hFFFF, 2'b00, 1'b1, 1'b1);
    step(16'h0000, 16'hDDDD, 16'hFFFF, 2'b01, 1'b1, 1'b1);
    check("selb_qr", 32'(q_r), 32'hDDDD);
    step(16'hEEEE, 16'h2222, 16'h0000, 2'b10, 1'b1, 1'b1);
    step(16'hEEEE, 16'h2222, 16'hFFFF, 2'b10, 1'b1, 1'b1);
    check("selc_qr", 32'(q_r), 32'hFFFF);

    // Reserved select, then recovery with the sticky flag held.
    step(16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 1'b1);
    check("rsvd_err", 32'(sel_err), 32'h1);
    step(16'hFFFF, 16'hDDDD, 16'hFFFF, 2'b01, 1'b1, 1'b1);
    check("rsvd_sticky", 32'(sel_err_sticky), 32'h1);

    // Hold with enable low, then capture again.
    step(16'h0, 16'h5555, 16'h0, 2'b01, 1'b0, 1'b1);
    check("hold_qr", 32'(q_r), 32'hDDDD);
    step(16'h0, 16'h5555, 16'h0, 2'b01, 1'b1, 1'b1);
    check("cap_qr", 32'(q_r), 32'h5555);

    // Reset clears sticky; the first edge after release captures.
    step(16'h1, 16'h2, 16'h3, 2'b11, 1'b1, 1'b0);
    step(16'h1, 16'h2, 16'h3, 2'b10, 1'b1, 1'b1);
    check("post_rst_qr", 32'(q_r), 32'h3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(W'($urandom), W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux3_select_reg.md
Name: mux3_select_reg

Overview:
- Three-input, word-wide data selector for the 16-bit processor datapath, e.g. choosing operand or writeback sources.
- A 2-bit select steers one of inputs A/B/C to a combinational output Q.
- The same selection is also captured into a registered output Q_r for timing-critical consumers.
- Reserved select code 2'b11 is flagged as a select error.

Parameters:
- WIDTH, 16, data width of A, B, C, Q, Q_r.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  capture enable for registered outputs.
- A  input  WIDTH  data source, selected by sel=2'b00.
- B  input  WIDTH  data source, selected by sel=2'b01.
- C  input  WIDTH  data source, selected by sel=2'b10.
- sel  input  2  source select.
- Q  output  WIDTH  combinational selected data.
- Q_r  output  WIDTH  registered selected data.
- sel_err  output  1  registered: last captured sel was 2'b11.
- sel_err_sticky  output  1  set on any captured 2'b11; cleared only by reset.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n); polarity and synchronicity are fixed.
- Q is purely combinational, with zero latency and no dependence on clk, rst_n or en:
  - sel=00 -> A
  - sel=01 -> B
  - sel=10 -> C
  - sel=11 -> all zeros (WIDTH'b0)
- Q must not infer latches. Any X/Z on sel drives Q to zero in synthesis; simulation X-propagation is acceptable.
- Reset: on a rising clk edge with rst_n=0, Q_r=0, sel_err=0, sel_err_sticky=0. Reset overrides en. Q is unaffected by reset.
- Capture: on a rising edge with rst_n=1 and en=1:
  - Q_r <= current Q value.
  - sel_err <= (sel==2'b11).
  - sel_err_sticky <= sel_err_sticky | (sel==2'b11).
- Hold: with rst_n=1 and en=0, Q_r, sel_err and sel_err_sticky hold their values.
- Latency: Q_r and sel_err reflect inputs sampled at the previous enabled edge (1 cycle).
- Reset deasserted mid-stream: the first enabled edge after release captures normally; there is no warm-up cycle.
- A/B/C are not registered internally. Q_r samples them at the edge, so setup is required relative to clk.
- No arithmetic; width is passed through unmodified; no sign extension.

Decomposition:
- Shared package mux_pkg:
  - SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_RSVD=2'b11.
  - Typedef sel_t (logic [1:0]).
- Sub-module mux3_core: parameterized combinational selector (A, B, C, sel -> Q, is_rsvd). Instantiated once.
- Top level mux3_select_reg holds the capture registers and the sticky flag.

Test Plan:
- Reset: rst_n=0 for 2 edges with A=16'h1234, en=1 -> Q_r=16'h0000, sel_err=0, sticky=0; Q=16'h1234 when sel=00.
- Select A: A=16'h0000, B=16'h0000, C=16'hFFFF, sel=00 -> Q=16'h0000 immediately; Q_r=16'h0000 after the next enabled edge.
- Select B: A=16'h0000, B=16'hDDDD, C=16'hFFFF, sel=01 -> Q=16'hDDDD; Q_r=16'hDDDD one cycle later; sel_err=0.
- Select C: A=16'hEEEE, B=16'h2222, C=16'h0000, sel=10 -> Q=16'h0000 (not EEEE or 2222); then C=16'hFFFF -> Q=16'hFFFF combinationally.
- Reserved select: A=B=C=16'hFFFF, sel=11 -> Q=16'h0000. After the edge: Q_r=16'h0000, sel_err=1, sticky=1. Then sel=01 -> sel_err=0, sticky stays 1 until rst_n=0.
- Hold: capture Q_r=16'hDDDD, set en=0, change B=16'h5555 -> Q=16'h5555, Q_r stays 16'hDDDD. Set en=1 -> Q_r=16'h5555 next edge.
